// File: rtl/display_scheduler.sv
// MAX7219 word sequencer: init words, 6-word frames per tick, host intensity.
// Optional: BLANK_LEADING_ZERO_EN blanks leading minute zeros.
// Ports: clk/res, ena, tick, digits, int_req/int_val/int_ack,
//        spi_ready/spi_sent/spi_cs/spi_word, init_done, busy, frame_ovr.
module display_scheduler #(
  parameter int         GAP_CYCLES  = 4,
  parameter logic [2:0] SCAN_LIMIT  = 3'd5,
  parameter logic [3:0] INT_DEFAULT = 4'h8
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        tick,
  input  logic [21:0] digits,
  input  logic        int_req,
  input  logic [3:0]  int_val,
  output logic        int_ack,
  input  logic        spi_ready,
  input  logic        spi_sent,
  output logic        spi_cs,
  output logic [15:0] spi_word,
  output logic        init_done,
  output logic        busy,
  output logic        frame_ovr
);

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_INTEN, S_FRAME
  } seq_t;

  typedef enum logic [1:0] {
    P_ISSUE, P_SENT, P_GAP
  } ph_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  seq_t        state_q, state_d;
  ph_t         phase_q, phase_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [21:0] snap_q, snap_d;
  logic [3:0]  ilat_q, ilat_d;
  logic        pend_q, pend_d;
  logic        tick_q;
  logic        cs_d, ack_d, done_d, ovr_d;
  logic [15:0] word_d, cur_word;
  logic [7:0]  fdata;
  logic [15:0] iword;
  logic        grant, edge_ok;

  always_comb begin
    unique case (idx_q)
      3'd0:    iword = 16'h0C01;
      3'd1:    iword = 16'h09FF;
      3'd2:    iword = {8'h0B, 5'b0, SCAN_LIMIT};
      3'd3:    iword = {8'h0A, 4'h0, INT_DEFAULT};
      default: iword = 16'h0F00;
    endcase
  end

  always_comb begin
    unique case (idx_q)
      3'd0:    fdata = {4'h0, snap_q[3:0]};
      3'd1:    fdata = {4'h0, snap_q[7:4]};
      3'd2:    fdata = {4'h8, snap_q[11:8]};
      3'd3:    fdata = {5'h0, snap_q[14:12]};
      3'd4:    fdata = {4'h8, snap_q[18:15]};
      3'd5:    fdata = {5'h0, snap_q[21:19]};
      default: fdata = 8'h00;
    endcase
`ifdef BLANK_LEADING_ZERO_EN
    // 0x0F is the code-B blank glyph; DP dropped with it
    if (snap_q[21:19] == 3'd0) begin
      if (idx_q == 3'd5)
        fdata = 8'h0F;
      if (idx_q == 3'd4 && snap_q[18:15] == 4'd0)
        fdata = 8'h0F;
    end
`endif
  end

  always_comb begin
    unique case (1'b1)
      state_q == S_INIT:  cur_word = iword;
      state_q == S_INTEN: cur_word = {8'h0A, 4'h0, ilat_q};
      state_q == S_FRAME:
        cur_word = {5'b0, 3'(idx_q + 3'd1), fdata};
      default:            cur_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    snap_d  = snap_q;
    ilat_d  = ilat_q;
    cs_d    = spi_cs;
    word_d  = spi_word;
    done_d  = init_done;
    ack_d   = 1'b0;
    grant   = 1'b0;
    if (state_q == S_IDLE) begin
      if (int_req) begin
        state_d = S_INTEN;
        phase_d = P_ISSUE;
        ilat_d  = int_val;
      end else if (pend_q) begin
        state_d = S_FRAME;
        phase_d = P_ISSUE;
        idx_d   = 3'd0;
        snap_d  = digits;
        grant   = 1'b1;
      end
    end else begin
      unique case (phase_q)
        P_ISSUE: if (spi_ready) begin
          word_d  = cur_word;
          cs_d    = 1'b0;
          phase_d = P_SENT;
        end
        P_SENT: if (spi_sent) begin
          cs_d    = 1'b1;
          gap_d   = 4'd0;
          phase_d = P_GAP;
        end
        P_GAP: if (gap_q == GAP_LAST) begin
          phase_d = P_ISSUE;
          idx_d   = idx_q + 3'd1;
          if (state_q == S_INIT && idx_q == 3'd4) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          if (state_q == S_FRAME && idx_q == 3'd5)
            state_d = S_IDLE;
          if (state_q == S_INTEN) begin
            state_d = S_IDLE;
            ack_d   = 1'b1;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
        default: phase_d = P_ISSUE;
      endcase
    end
  end

  // One pending frame at most; a second edge only flags overrun
  always_comb begin
    edge_ok = tick & ~tick_q & ena & init_done;
    pend_d  = pend_q;
    ovr_d   = 1'b0;
    if (grant)
      pend_d = 1'b0;
    if (edge_ok) begin
      ovr_d  = pend_q & ~grant;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_INIT;
      phase_q   <= P_ISSUE;
      idx_q     <= 3'd0;
      gap_q     <= 4'd0;
      snap_q    <= 22'd0;
      ilat_q    <= 4'd0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      spi_cs    <= 1'b1;
      spi_word  <= 16'h0000;
      int_ack   <= 1'b0;
      init_done <= 1'b0;
      frame_ovr <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      snap_q    <= snap_d;
      ilat_q    <= ilat_d;
      pend_q    <= pend_d;
      tick_q    <= tick;
      spi_cs    <= cs_d;
      spi_word  <= word_d;
      int_ack   <= ack_d;
      init_done <= done_d;
      frame_ovr <= ovr_d;
    end
  end

  // Gated by reset so busy reads 0 while held in reset
  assign busy = res & (state_q != S_IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a small SPI master model.
`timescale 1ns/1ps
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        res;
  logic        ena;
  logic        tick;
  logic [21:0] digits;
  logic        int_req;
  logic [3:0]  int_val;
  logic        int_ack;
  logic        spi_ready;
  logic        spi_sent;
  logic        spi_cs;
  logic [15:0] spi_word;
  logic        init_done;
  logic        busy;
  logic        frame_ovr;

  int tests = 0;
  int fails = 0;
  logic [15:0] wq[$];
  int acks = 0;
  int ack_pos = 0;
  int ovrs = 0;
  int mcnt = 0;
  logic prev_cs = 1'b1;

  display_scheduler dut (
    .clk(clk), .res(res), .ena(ena), .tick(tick),
    .digits(digits), .int_req(int_req),
    .int_val(int_val), .int_ack(int_ack),
    .spi_ready(spi_ready), .spi_sent(spi_sent),
    .spi_cs(spi_cs), .spi_word(spi_word),
    .init_done(init_done), .busy(busy),
    .frame_ovr(frame_ovr)
  );

  always #500 clk = ~clk;

  // Master model and word/pulse monitor
  always @(negedge clk) begin
    if (!res) begin
      prev_cs   = 1'b1;
      mcnt      = 0;
      spi_sent  = 1'b0;
      spi_ready = 1'b0;
    end else begin
      if (prev_cs && !spi_cs)
        wq.push_back(spi_word);
      if (int_ack) begin
        acks++;
        ack_pos = wq.size();
      end
      if (frame_ovr)
        ovrs++;
      if (!spi_cs) begin
        mcnt++;
        spi_ready = 1'b0;
        spi_sent  = (mcnt == 3);
      end else begin
        mcnt      = 0;
        spi_ready = 1'b1;
        spi_sent  = 1'b0;
      end
      prev_cs = spi_cs;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input string tag);
    int c = 0;
    while (wq.size() < n && c < 2000) begin
      step();
      c++;
    end
    check(tag, 32'(wq.size() >= n), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int c = 0;
    while (!init_done && c < 2000) begin
      step();
      c++;
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step();
  endtask

  task automatic check_init(input string tag);
    check({tag, "_w0"}, 32'(wq[0]), 32'h0C01);
    check({tag, "_w1"}, 32'(wq[1]), 32'h09FF);
    check({tag, "_w2"}, 32'(wq[2]), 32'h0B05);
    check({tag, "_w3"}, 32'(wq[3]), 32'h0A08);
    check({tag, "_w4"}, 32'(wq[4]), 32'h0F00);
  endtask

  task automatic check_frame(input string tag, input int b);
    check({tag, "_f1"}, 32'(wq[b]),   32'h0106);
    check({tag, "_f2"}, 32'(wq[b+1]), 32'h0205);
    check({tag, "_f3"}, 32'(wq[b+2]), 32'h0384);
    check({tag, "_f4"}, 32'(wq[b+3]), 32'h0403);
    check({tag, "_f5"}, 32'(wq[b+4]), 32'h0582);
    check({tag, "_f6"}, 32'(wq[b+5]), 32'h0601);
  endtask

  initial begin
    int c;
    int o0;
    res     = 1'b0;
    ena     = 1'b0;
    tick    = 1'b0;
    digits  = 22'd0;
    int_req = 1'b0;
    int_val = 4'd0;
    idle(3);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_word", 32'(spi_word), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(int_ack), 32'd0);
    check("rst_ovr", 32'(frame_ovr), 32'd0);

    res = 1'b1;
    step();
    check("init_busy", 32'(busy), 32'd1);
    wait_words(5, "init_words");
    check("init_early", 32'(init_done), 32'd0);
    wait_init("init_done");
    check_init("init");
    check("init_cnt", 32'(wq.size()), 32'd5);
    check("idle_busy", 32'(busy), 32'd0);

    // single frame, min 12 sec 34 ces 56
    wq.delete();
    ena    = 1'b1;
    digits = {3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6};
    tick   = 1'b1;
    wait_words(6, "fr_words");
    tick = 1'b0;
    idle(20);
    check_frame("fr", 0);
    check("fr_cnt", 32'(wq.size()), 32'd6);

    // intensity request mid-frame, next frame pending
    wq.delete();
    o0   = ovrs;
    tick = 1'b1;
    wait_words(1, "int_a");
    tick = 1'b0;
    wait_words(2, "int_b");
    int_req = 1'b1;
    int_val = 4'd3;
    tick    = 1'b1;
    c = 0;
    while (acks == 0 && c < 2000) begin
      step();
      c++;
    end
    int_req = 1'b0;
    check("int_acked", 32'(acks), 32'd1);
    check("int_pos", 32'(ack_pos), 32'd7);
    wait_words(13, "int_words");
    idle(100);
    check("int_cnt", 32'(wq.size()), 32'd13);
    check_frame("int1", 0);
    check("int_word", 32'(wq[6]), 32'h0A03);
    check_frame("int2", 7);
    check("int_acks", 32'(acks), 32'd1);
    check("int_novr", 32'(ovrs - o0), 32'd0);

    // three edges around one frame: one overrun
    wq.delete();
    tick = 1'b0;
    step();
    tick = 1'b1;
    wait_words(1, "ovr_a");
    tick = 1'b0;
    step();
    tick = 1'b1;
    wait_words(2, "ovr_b");
    tick = 1'b0;
    step();
    tick = 1'b1;
    wait_words(12, "ovr_words");
    idle(150);
    check("ovr_cnt", 32'(wq.size()), 32'd12);
    check("ovr_pulses", 32'(ovrs - o0), 32'd1);
    check_frame("ovr2", 6);

    // ena low blocks new frames
    wq.delete();
    o0   = ovrs;
    tick = 1'b0;
    step();
    ena  = 1'b0;
    tick = 1'b1;
    idle(100);
    check("ena_cnt", 32'(wq.size()), 32'd0);
    check("ena_ovr", 32'(ovrs - o0), 32'd0);
    check("ena_busy", 32'(busy), 32'd0);

    // reset during word 3 of a frame
    ena  = 1'b1;
    tick = 1'b0;
    step();
    tick = 1'b1;
    wait_words(3, "rr_words");
    check("rr_cs_low", 32'(spi_cs), 32'd0);
    res = 1'b0;
    #1;
    check("rr_cs_hi", 32'(spi_cs), 32'd1);
    check("rr_done", 32'(init_done), 32'd0);
    tick = 1'b0;
    idle(3);
    wq.delete();
    res = 1'b1;
    wait_words(5, "rr_init");
    wait_init("rr_done2");
    check_init("rr");

    // leading zero minutes
    wq.delete();
    digits = {3'd0, 4'd0, 3'd3, 4'd4, 4'd5, 4'd6};
    tick   = 1'b1;
    wait_words(6, "bz_words");
    check("bz_w1", 32'(wq[0]), 32'h0106);
`ifdef BLANK_LEADING_ZERO_EN
    check("bz_w5", 32'(wq[4]), 32'h050F);
    check("bz_w6", 32'(wq[5]), 32'h060F);
`else
    check("bz_w5", 32'(wq[4]), 32'h0580);
    check("bz_w6", 32'(wq[5]), 32'h0600);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
